// File: rtl/fmul_issue_arbiter.sv
// Round-robin issue arbiter sharing one pipelined fmul among N requesters; grant and operand
// drive are combinational, and requester index/tag ride a LATENCY-deep shadow pipe to the response.
module fmul_issue_arbiter #(
  parameter int N       = 4,
  parameter int TAG_W   = 4,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [N*32-1:0]      req_x1,
  input  logic [N*32-1:0]      req_x2,
  input  logic [N*TAG_W-1:0]   req_tag,
  input  logic                 flush,
  output logic [31:0]          mul_x1,
  output logic [31:0]          mul_x2,
  input  logic [31:0]          mul_y,
  output logic [N-1:0]         rsp_valid,
  output logic [31:0]          rsp_y,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 busy
);

  localparam int            IW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW:0]   N_W  = (IW+1)'(N);
  localparam logic [IW-1:0] LAST = IW'(N-1);

  logic [31:0]      x1_a  [N];
  logic [31:0]      x2_a  [N];
  logic [TAG_W-1:0] tag_a [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign x1_a[i]  = req_x1[32*i +: 32];
    assign x2_a[i]  = req_x2[32*i +: 32];
    assign tag_a[i] = req_tag[TAG_W*i +: TAG_W];
  end

  logic [IW-1:0]      ptr_q, ptr_d;
  logic               gnt_vld;
  logic [IW-1:0]      gnt_idx;
  logic [IW:0]        cand;

  logic [LATENCY-1:0] v_q;
  logic [IW-1:0]      idx_q [LATENCY];
  logic [TAG_W-1:0]   tag_q [LATENCY];

  // Scan from the far end back toward ptr so the closest valid requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = N-1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= N_W) cand = cand - N_W;
      if (req_valid[cand[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IW-1:0];
      end
    end
    if (!rstn) gnt_vld = 1'b0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + IW'(1);
  end

  for (genvar i = 0; i < N; i++) begin : g_onehot
    assign req_ready[i] = gnt_vld && (gnt_idx == IW'(i));
    assign rsp_valid[i] = v_q[LATENCY-1] && (idx_q[LATENCY-1] == IW'(i));
  end

  assign mul_x1  = gnt_vld ? x1_a[gnt_idx] : 32'h0;
  assign mul_x2  = gnt_vld ? x2_a[gnt_idx] : 32'h0;
  assign rsp_y   = mul_y;
  assign rsp_tag = tag_q[LATENCY-1];
  assign busy    = |v_q;

  // Flush kills every valid bit, including the one being accepted this cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q <= '0;
      v_q   <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        idx_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      ptr_q    <= ptr_d;
      v_q[0]   <= gnt_vld & ~flush;
      idx_q[0] <= gnt_idx;
      tag_q[0] <= tag_a[gnt_idx];
      for (int k = 1; k < LATENCY; k++) begin
        v_q[k]   <= v_q[k-1] & ~flush;
        idx_q[k] <= idx_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_fmul_issue_arbiter.sv
// Directed bench for fmul_issue_arbiter with a 2-stage behavioural fmul for the operand pairs used.
module tb_fmul_issue_arbiter;

  localparam int N     = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*32-1:0]  req_x1, req_x2;
  logic [N*TAG_W-1:0] req_tag;
  logic             flush;
  logic [31:0]      mul_x1, mul_x2, mul_y;
  logic [N-1:0]     rsp_valid;
  logic [31:0]      rsp_y;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  fmul_issue_arbiter #(.N(N), .TAG_W(TAG_W), .LATENCY(2)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag), .flush(flush),
    .mul_x1(mul_x1), .mul_x2(mul_x2), .mul_y(mul_y),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_tag(rsp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3FC00000, 32'h40000000}: return 32'h40400000;
      {32'h3F800000, 32'h3F800000}: return 32'h3F800000;
      {32'h00000000, 32'h40000000}: return 32'h00000000;
      {32'h7F800000, 32'h3F800000}: return 32'h7F800000;
      default:                      return 32'hFFFFFFFF;
    endcase
  endfunction

  logic [31:0] p1;
  always @(posedge clk) begin
    if (!rstn) begin
      p1    <= '0;
      mul_y <= '0;
    end else begin
      p1    <= fmul_ref(mul_x1, mul_x2);
      mul_y <= p1;
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then driven and sampled #1 later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t);
    req_valid[i]              = 1'b1;
    req_x1[32*i +: 32]        = a;
    req_x2[32*i +: 32]        = b;
    req_tag[TAG_W*i +: TAG_W] = t;
  endtask

  task automatic do_reset();
    rstn = 1'b0; req_valid = '0; flush = 1'b0;
    cyc(); cyc();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; req_valid = '0; req_x1 = '0; req_x2 = '0; req_tag = '0; flush = 1'b0;
    cyc();
    // Ready and operands are suppressed while in reset even with a valid request.
    set_req(0, 32'h3F800000, 32'h3F800000, 4'h1);
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_mulx1", mul_x1, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    req_valid = '0;
    cyc();
    rstn = 1'b1;

    // Single request
    cyc();
    set_req(0, 32'h3FC00000, 32'h40000000, 4'h5);
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    check("single_mulx1", mul_x1, 32'h3FC00000);
    check("single_mulx2", mul_x2, 32'h40000000);
    cyc(); req_valid = '0; #1;
    check("single_busy_t1", 32'(busy), 32'h1);
    check("single_novld_t1", 32'(rsp_valid), 32'h0);
    cyc(); #1;
    check("single_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_rsp_y", rsp_y, 32'h40400000);
    check("single_rsp_tag", 32'(rsp_tag), 32'h5);
    check("single_busy_t2", 32'(busy), 32'h1);
    cyc(); #1;
    check("single_idle", 32'(busy), 32'h0);
    check("single_idle_mulx", mul_x1, 32'h0);

    // Full contention from ptr=0
    do_reset();
    for (int c = 0; c < 8; c++) begin
      cyc();
      req_valid = '0;
      if (c < 6)
        for (int i = 0; i < N; i++) set_req(i, 32'h3F800000, 32'h3F800000, TAG_W'(i + 8));
      #1;
      check("rr_ready", 32'(req_ready), (c < 6) ? (32'h1 << (c % 4)) : 32'h0);
      if (c >= 2) begin
        check("rr_rsp_valid", 32'(rsp_valid), 32'h1 << ((c - 2) % 4));
        check("rr_rsp_y", rsp_y, 32'h3F800000);
        check("rr_rsp_tag", 32'(rsp_tag), 32'((c - 2) % 4 + 8));
      end else begin
        check("rr_rsp_none", 32'(rsp_valid), 32'h0);
      end
    end

    // Pointer skip: ptr=2 now; req0 alone moves ptr to 1
    cyc(); req_valid = '0;
    set_req(0, 32'h3F800000, 32'h3F800000, 4'h1); #1;
    check("skip_g0", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    set_req(3, 32'h3F800000, 32'h3F800000, 4'h2); #1;
    check("skip_g3", 32'(req_ready), 32'h8);
    cyc(); req_valid = '0;
    set_req(0, 32'h3F800000, 32'h3F800000, 4'h3);
    set_req(3, 32'h3F800000, 32'h3F800000, 4'h4); #1;
    check("skip_wrap_g0", 32'(req_ready), 32'h1);
    check("skip_rsp0", 32'(rsp_valid), 32'h1);
    check("skip_rsp0_tag", 32'(rsp_tag), 32'h1);
    cyc(); req_valid = '0;
    set_req(3, 32'h3F800000, 32'h3F800000, 4'h4); #1;
    check("skip_held_g3", 32'(req_ready), 32'h8);
    check("skip_rsp3", 32'(rsp_valid), 32'h8);
    check("skip_rsp3_tag", 32'(rsp_tag), 32'h2);
    cyc(); req_valid = '0; #1;
    check("skip_rsp_wrap", 32'(rsp_valid), 32'h1);
    check("skip_rsp_wrap_tag", 32'(rsp_tag), 32'h3);
    cyc(); #1;
    check("skip_rsp_held", 32'(rsp_valid), 32'h8);
    check("skip_rsp_held_tag", 32'(rsp_tag), 32'h4);

    // Zero / infinity passthrough; ptr=0
    cyc(); req_valid = '0;
    set_req(2, 32'h00000000, 32'h40000000, 4'hA); #1;
    check("zi_g2", 32'(req_ready), 32'h4);
    cyc(); req_valid = '0;
    set_req(1, 32'h7F800000, 32'h3F800000, 4'h3); #1;
    check("zi_g1", 32'(req_ready), 32'h2);
    cyc(); req_valid = '0; #1;
    check("zi_zero_vld", 32'(rsp_valid), 32'h4);
    check("zi_zero_y", rsp_y, 32'h00000000);
    check("zi_zero_tag", 32'(rsp_tag), 32'hA);
    cyc(); #1;
    check("zi_inf_vld", 32'(rsp_valid), 32'h2);
    check("zi_inf_y", rsp_y, 32'h7F800000);
    check("zi_inf_tag", 32'(rsp_tag), 32'h3);

    // Flush: ptr=2 after grant 1
    do_reset();
    cyc(); req_valid = '0;
    set_req(0, 32'h3F800000, 32'h3F800000, 4'h1); #1;
    check("fl_g0", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0; flush = 1'b1;
    set_req(1, 32'h3F800000, 32'h3F800000, 4'h2); #1;
    check("fl_g1_consumed", 32'(req_ready), 32'h2);
    cyc(); req_valid = '0; flush = 1'b0;
    set_req(2, 32'h3F800000, 32'h3F800000, 4'h7); #1;
    check("fl_ptr_adv_g2", 32'(req_ready), 32'h4);
    check("fl_no_rsp_t2", 32'(rsp_valid), 32'h0);
    check("fl_busy_t2", 32'(busy), 32'h0);
    cyc(); req_valid = '0; #1;
    check("fl_no_rsp_t3", 32'(rsp_valid), 32'h0);
    check("fl_busy_t3", 32'(busy), 32'h1);
    cyc(); #1;
    check("fl_new_rsp", 32'(rsp_valid), 32'h4);
    check("fl_new_tag", 32'(rsp_tag), 32'h7);
    check("fl_new_y", rsp_y, 32'h3F800000);

    // Reset mid-op: ptr=3, grant 1 would leave ptr=2 without the reset
    cyc(); req_valid = '0;
    set_req(1, 32'h3F800000, 32'h3F800000, 4'h9); #1;
    check("ro_g1", 32'(req_ready), 32'h2);
    cyc(); rstn = 1'b0; req_valid = '0;
    set_req(0, 32'h3F800000, 32'h3F800000, 4'h1); #1;
    check("ro_ready_in_rst", 32'(req_ready), 32'h0);
    cyc(); rstn = 1'b1; req_valid = '0;
    set_req(0, 32'h3F800000, 32'h3F800000, 4'h1);
    set_req(2, 32'h3F800000, 32'h3F800000, 4'h2); #1;
    check("ro_no_rsp", 32'(rsp_valid), 32'h0);
    check("ro_busy", 32'(busy), 32'h0);
    check("ro_ptr0_g0", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
